// File: rtl/kesme_denetleyici_pkg.sv
// kesme_denetleyici_pkg: interrupt codes, mie/mip bit positions, timer register map and FSM states
package kesme_denetleyici_pkg;
  localparam int KOD_MSI = 3;
  localparam int KOD_MTI = 7;
  localparam int KOD_MEI = 11;
  localparam int BIT_MSI = 3;
  localparam int BIT_MTI = 7;
  localparam int BIT_MEI = 11;
  localparam logic [1:0] ADR_MTIME_LO = 2'd0;
  localparam logic [1:0] ADR_MTIME_HI = 2'd1;
  localparam logic [1:0] ADR_CMP_LO = 2'd2;
  localparam logic [1:0] ADR_CMP_HI = 2'd3;
  typedef enum logic [1:0] {BOSTA, ISTEK, SUN, BEKLE} durum_t;
  function automatic logic [3:0] oncelik(input logic p11, input logic p3);
    return p11 ? 4'(KOD_MEI) : p3 ? 4'(KOD_MSI) : 4'(KOD_MTI);
  endfunction
endpackage

// File: rtl/kesme_denetleyici_zamanlayici.sv
// kesme_denetleyici_zamanlayici: 64-bit mtime/mtimecmp with prescaler, register port and registered mtip
module kesme_denetleyici_zamanlayici
  import kesme_denetleyici_pkg::*;
#(
  parameter int ONBOLUCU = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        yaz_gecerli_i,
  input  logic [1:0]  yaz_adres_i,
  input  logic [31:0] yaz_veri_i,
  input  logic [1:0]  oku_adres_i,
  output logic [31:0] oku_veri_o,
  output logic        mtip_o
);
  logic [31:0] r_bolucu;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_mtip;
  logic        w_tik;
  assign w_tik = r_bolucu == 32'(ONBOLUCU - 1);
  assign mtip_o = r_mtip;
  // an mtime write wins over the tick for all 64 bits, so a carry never lands in the held half
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_bolucu <= '0;
      r_mtime <= '0;
      r_mtimecmp <= '1;
      r_mtip <= 1'b0;
    end else begin
      r_bolucu <= w_tik ? '0 : r_bolucu + 32'd1;
      if (yaz_gecerli_i && yaz_adres_i == ADR_MTIME_LO) r_mtime[31:0] <= yaz_veri_i;
      else if (yaz_gecerli_i && yaz_adres_i == ADR_MTIME_HI) r_mtime[63:32] <= yaz_veri_i;
      else if (w_tik) r_mtime <= r_mtime + 64'd1;
      if (yaz_gecerli_i && yaz_adres_i == ADR_CMP_LO) r_mtimecmp[31:0] <= yaz_veri_i;
      if (yaz_gecerli_i && yaz_adres_i == ADR_CMP_HI) r_mtimecmp[63:32] <= yaz_veri_i;
      r_mtip <= r_mtime >= r_mtimecmp;
    end
  always_comb
    oku_veri_o = oku_adres_i == ADR_MTIME_LO ? r_mtime[31:0] :
                 oku_adres_i == ADR_MTIME_HI ? r_mtime[63:32] :
                 oku_adres_i == ADR_CMP_LO   ? r_mtimecmp[31:0] : r_mtimecmp[63:32];
endmodule

// File: rtl/kesme_denetleyici.sv
// kesme_denetleyici: machine-mode interrupt controller; waits for an instruction boundary,
// then holds one trap request (cause, resume PS) until the CSR unit accepts it.
module kesme_denetleyici
  import kesme_denetleyici_pkg::*;
#(
  parameter int MXLEN    = 32,
  parameter int PS_BIT   = 32,
  parameter int ONBOLUCU = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              meip_i,
  input  logic              msip_i,
  input  logic              mstatus_mie_i,
  input  logic [MXLEN-1:0]  mie_i,
  input  logic              senkron_odd_i,
  input  logic              hat_bos_i,
  input  logic [PS_BIT-1:0] sonraki_ps_i,
  input  logic              odd_kabul_i,
  input  logic              yaz_gecerli_i,
  input  logic [1:0]        yaz_adres_i,
  input  logic [31:0]       yaz_veri_i,
  input  logic [1:0]        oku_adres_i,
  output logic [31:0]       oku_veri_o,
  output logic [MXLEN-1:0]  mip_o,
  output logic              durdur_o,
  output logic              odd_gecerli_o,
  output logic [MXLEN-1:0]  odd_kod_o,
  output logic [PS_BIT-1:0] odd_ps_o
);
  durum_t            r_durum;
  logic              r_meip_s1;
  logic              r_meip_s2;
  logic              r_durdur;
  logic              r_gecerli;
  logic [MXLEN-1:0]  r_kod;
  logic [PS_BIT-1:0] r_ps;
  logic              w_mtip;
  logic              w_p11;
  logic              w_p3;
  logic              w_p7;
  logic              w_kesme;
  logic              w_unused;
  kesme_denetleyici_zamanlayici #(.ONBOLUCU(ONBOLUCU)) u_zamanlayici (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .yaz_gecerli_i (yaz_gecerli_i),
    .yaz_adres_i   (yaz_adres_i),
    .yaz_veri_i    (yaz_veri_i),
    .oku_adres_i   (oku_adres_i),
    .oku_veri_o    (oku_veri_o),
    .mtip_o        (w_mtip)
  );
  assign w_p11 = r_meip_s2 & mie_i[BIT_MEI];
  assign w_p3 = msip_i & mie_i[BIT_MSI];
  assign w_p7 = w_mtip & mie_i[BIT_MTI];
  assign w_kesme = mstatus_mie_i & (w_p11 | w_p3 | w_p7);
  assign w_unused = ^mie_i;
  assign durdur_o = r_durdur;
  assign odd_gecerli_o = r_gecerli;
  assign odd_kod_o = r_kod;
  assign odd_ps_o = r_ps;
  always_comb begin
    mip_o = '0;
    mip_o[BIT_MEI] = r_meip_s2;
    mip_o[BIT_MTI] = w_mtip;
    mip_o[BIT_MSI] = msip_i;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_meip_s1 <= 1'b0;
      r_meip_s2 <= 1'b0;
    end else begin
      r_meip_s1 <= meip_i;
      r_meip_s2 <= r_meip_s1;
    end
  // once in SUN the trap is committed: senkron_odd_i no longer matters there
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_durum <= BOSTA;
      r_durdur <= 1'b0;
      r_gecerli <= 1'b0;
      r_kod <= '0;
      r_ps <= '0;
    end else begin
      case (r_durum)
        BOSTA:
          if (w_kesme && !senkron_odd_i) begin
            r_durum <= ISTEK;
            r_durdur <= 1'b1;
          end
        ISTEK:
          if (senkron_odd_i || hat_bos_i) begin
            r_durdur <= 1'b0;
            r_durum <= (!senkron_odd_i && w_kesme) ? SUN : BOSTA;
            if (!senkron_odd_i && w_kesme) begin
              r_gecerli <= 1'b1;
              r_kod <= (MXLEN'(1) << (MXLEN - 1)) | MXLEN'(oncelik(w_p11, w_p3));
              r_ps <= sonraki_ps_i;
            end
          end
        SUN:
          if (odd_kabul_i) begin
            r_durum <= BEKLE;
            r_gecerli <= 1'b0;
          end
        default: r_durum <= BOSTA;
      endcase
    end
endmodule

// File: doc/kesme_denetleyici.md
Name: kesme_denetleyici

Overview:
- Machine-mode interrupt controller and timer that schedules asynchronous trap entry into the CSR/trap unit.
- Holds a 64-bit mtime/mtimecmp pair, synchronises the external interrupt line, prioritises enabled pending interrupts and stalls the front end until the pipeline reaches an instruction boundary.
- Then presents a single trap request (cause, resume PS) to the CSR unit's trap input and holds it until accepted.
- Synchronous exceptions from the pipeline always win over a not-yet-committed interrupt.

Parameters:
MXLEN, 32, CSR/data width
PS_BIT, 32, program counter width
ONBOLUCU, 1, mtime increments once every ONBOLUCU cycles (>=1)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
meip_i  input  1  external interrupt line, asynchronous level
msip_i  input  1  software interrupt level, synchronous
mstatus_mie_i  input  1  global machine interrupt enable from CSR unit
mie_i  input  MXLEN  mie CSR from CSR unit (bits 3, 7, 11 used)
senkron_odd_i  input  1  a synchronous exception/flush is being taken this cycle
hat_bos_i  input  1  no older instruction in flight and no younger issued (boundary reached)
sonraki_ps_i  input  PS_BIT  PS of the next instruction to execute at the boundary
odd_kabul_i  input  1  CSR unit accepted the trap this cycle
yaz_gecerli_i  input  1  timer register write strobe
yaz_adres_i  input  2  0 mtime lo, 1 mtime hi, 2 mtimecmp lo, 3 mtimecmp hi
yaz_veri_i  input  32  write data
oku_adres_i  input  2  read address, same map as writes
oku_veri_o  output  32  combinational read data of the addressed register
mip_o  output  MXLEN  live mip image (bits 3, 7, 11), others 0
durdur_o  output  1  stall front end; high in ISTEK
odd_gecerli_o  output  1  trap request to CSR unit; high in SUN
odd_kod_o  output  MXLEN  mcause: bit MXLEN-1 = 1, low bits 11/3/7
odd_ps_o  output  PS_BIT  resume PS, written to mepc by the CSR unit

Behaviour:
- Reset values (asynchronous): mtime = 0, mtimecmp = all ones, prescaler = 0, meip sync flops = 0, state = BOSTA, durdur_o = 0, odd_gecerli_o = 0, odd_kod_o = 0, odd_ps_o = 0.
- Reset mid-trap drops the request immediately.
- Timer:
  - Prescaler counts 0..ONBOLUCU-1; on wrap, mtime += 1 (64-bit, wraps to 0 after all ones).
  - A write to an mtime half in the same cycle overrides the increment for the whole of mtime: the written half takes the new value, the other half is held.
  - mtimecmp writes take effect next cycle.
  - mtip = registered (mtime >= mtimecmp), unsigned 64-bit, so it lags the compare by one cycle.
- meip_i passes through a 2-flop synchroniser before use.
- Pending terms: p11 = meip_s & mie[11], p3 = msip & mie[3], p7 = mtip & mie[7]. kesme = mstatus_mie_i & (p11 | p3 | p7).
- Priority: 11 > 3 > 7.
- State machine:
  - BOSTA: if kesme & !senkron_odd_i, go to ISTEK next cycle.
  - ISTEK: durdur_o = 1.
    - If senkron_odd_i, go to BOSTA (the exception owns the flush).
    - Else if hat_bos_i and kesme, latch odd_ps_o = sonraki_ps_i, latch odd_kod_o from the highest-priority pending term evaluated this cycle, and go to SUN.
    - Else if hat_bos_i and !kesme (interrupt withdrawn), go to BOSTA.
    - Otherwise stay.
  - SUN: odd_gecerli_o = 1; cause and PS are held stable. senkron_odd_i is ignored (trap already committed). When odd_kabul_i, go to BEKLE.
  - BEKLE: one cycle, no new request. This covers the CSR unit's registered MIE clear. Then go to BOSTA.
- odd_kabul_i outside SUN is ignored.
- Back-to-back interrupts are taken only after the handler re-enables MIE; the controller relies on mstatus_mie_i, not internal masking.
- Latency: pending → durdur_o is 1 cycle; hat_bos_i → odd_gecerli_o is 1 cycle.

Decomposition:
- Shared constants go in sabitler.vh/csr.vh: interrupt codes 3/7/11, mie/mip bit positions, timer register addresses, state encodings.
- Sub-module: kesme_zamanlayici (mtime, mtimecmp, prescaler, write/read port, mtip). The FSM and priority logic stay in the top.

Test Plan:
1. Reset, then read mtime lo after 10 cycles (ONBOLUCU=1) → 10. mtimecmp reads 0xFFFFFFFF for both halves. All outputs 0 during and after reset.
2. Write mtimecmp = 20, mie[7] = 1, mstatus_mie_i = 1, hat_bos_i = 1 → durdur_o rises at mtime ≥ 20 + 2 cycles. odd_gecerli_o follows one cycle later with odd_kod_o = 0x80000007 and odd_ps_o = sonraki_ps_i. It holds until odd_kabul_i, then BEKLE and BOSTA.
3. meip_i and msip_i both asserted with mie bits 11 and 3 set → odd_kod_o = 0x8000000B. The synchroniser gives 2 cycles extra latency versus msip alone.
4. In ISTEK, assert senkron_odd_i → durdur_o drops next cycle and no odd_gecerli_o appears. Asserting senkron_odd_i in SUN changes nothing.
5. Write mtime lo = 0xFFFFFFFF, hi = 0 → one increment later, hi = 1 and lo = 0. A write in the same cycle as an increment keeps the written value.
6. Assert rst_i while in SUN → odd_gecerli_o drops in the same cycle, mtime returns to 0, and mtimecmp returns to all ones.
